// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one memory port between
// instruction fetch (port 0) and the data memory unit (port 1).
//
// Ports:
//   clock, reset         : clock, synchronous active-high reset
//   p0_* / p1_*          : requester ports (read/write level requests,
//                          address, write data, read data, returned
//                          address, 1-cycle valid, ready)
//   mem_read/mem_write   : downstream command, held until completion
//   mem_address/in_data  : downstream address and write data
//   mem_out_data/addr    : downstream response data and address
//   mem_valid/mem_ready  : downstream completion pulse and accept flag
//   timeout_err          : 1-cycle pulse when a hung access is aborted
//   grant                : port currently or last granted
module mem_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDRESS_BITS = 20,
    parameter int TIMEOUT      = 255
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    p0_read,
    input  logic                    p0_write,
    input  logic [ADDRESS_BITS-1:0] p0_address,
    input  logic [DATA_WIDTH-1:0]   p0_in_data,
    output logic [DATA_WIDTH-1:0]   p0_out_data,
    output logic [ADDRESS_BITS-1:0] p0_out_addr,
    output logic                    p0_valid,
    output logic                    p0_ready,
    input  logic                    p1_read,
    input  logic                    p1_write,
    input  logic [ADDRESS_BITS-1:0] p1_address,
    input  logic [DATA_WIDTH-1:0]   p1_in_data,
    output logic [DATA_WIDTH-1:0]   p1_out_data,
    output logic [ADDRESS_BITS-1:0] p1_out_addr,
    output logic                    p1_valid,
    output logic                    p1_ready,
    output logic                    mem_read,
    output logic                    mem_write,
    output logic [ADDRESS_BITS-1:0] mem_address,
    output logic [DATA_WIDTH-1:0]   mem_in_data,
    input  logic [DATA_WIDTH-1:0]   mem_out_data,
    input  logic [ADDRESS_BITS-1:0] mem_out_addr,
    input  logic                    mem_valid,
    input  logic                    mem_ready,
    output logic                    timeout_err,
    output logic                    grant
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    localparam logic [15:0] TMO = 16'(TIMEOUT);

    state_t r_state;
    state_t w_state_nx;

    logic                    r_grant;
    logic                    r_rd;
    logic                    r_wr;
    logic [ADDRESS_BITS-1:0] r_addr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [15:0]             r_wdog;
    logic [DATA_WIDTH-1:0]   r_p0_data;
    logic [DATA_WIDTH-1:0]   r_p1_data;
    logic [ADDRESS_BITS-1:0] r_p0_addr;
    logic [ADDRESS_BITS-1:0] r_p1_addr;
    logic                    r_p0_valid;
    logic                    r_p1_valid;
    logic                    r_tmo;

    logic                    w_req0;
    logic                    w_req1;
    logic                    w_sel;
    logic                    w_sel_wr;
    logic [ADDRESS_BITS-1:0] w_sel_addr;
    logic [DATA_WIDTH-1:0]   w_sel_data;
    logic                    w_wdog_hit;
    logic                    w_accept;
    logic                    w_done;
    logic                    w_abort;

    assign w_req0 = p0_read | p0_write;
    assign w_req1 = p1_read | p1_write;

    // On a tie the port that did not win last time goes next.
    assign w_sel = (w_req0 && w_req1) ? ~r_grant : w_req1;

    // Write takes precedence when a port raises both read and write.
    assign w_sel_wr   = w_sel ? p1_write   : p0_write;
    assign w_sel_addr = w_sel ? p1_address : p0_address;
    assign w_sel_data = w_sel ? p1_in_data : p0_in_data;

    // r_wdog holds the number of BUSY cycles already completed, so the
    // abort fires at the end of BUSY cycle number TIMEOUT.
    assign w_wdog_hit = (TMO != 16'd0) && (r_wdog == TMO - 16'd1);

    always_comb begin
        w_state_nx = r_state;
        w_accept   = 1'b0;
        w_done     = 1'b0;
        w_abort    = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (mem_ready && (w_req0 || w_req1)) begin
                    w_accept   = 1'b1;
                    w_state_nx = BUSY;
                end
            end
            BUSY: begin
                if (mem_valid) begin
                    w_done     = 1'b1;
                    w_state_nx = RESP;
                end else if (w_wdog_hit) begin
                    w_abort    = 1'b1;
                    w_state_nx = IDLE;
                end
            end
            RESP: begin
                w_state_nx = IDLE;
            end
            default: begin
                w_state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_grant    <= 1'b1;
            r_rd       <= 1'b0;
            r_wr       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_wdog     <= '0;
            r_p0_data  <= '0;
            r_p1_data  <= '0;
            r_p0_addr  <= '0;
            r_p1_addr  <= '0;
            r_p0_valid <= 1'b0;
            r_p1_valid <= 1'b0;
            r_tmo      <= 1'b0;
        end else begin
            r_p0_valid <= 1'b0;
            r_p1_valid <= 1'b0;
            r_tmo      <= 1'b0;
            if (r_state == BUSY) begin
                r_wdog <= r_wdog + 16'd1;
            end
            if (w_accept) begin
                r_grant <= w_sel;
                r_wr    <= w_sel_wr;
                r_rd    <= ~w_sel_wr;
                r_addr  <= w_sel_addr;
                r_wdata <= w_sel_data;
                r_wdog  <= '0;
            end
            if (w_done) begin
                r_rd <= 1'b0;
                r_wr <= 1'b0;
                if (r_grant) begin
                    r_p1_data  <= mem_out_data;
                    r_p1_addr  <= mem_out_addr;
                    r_p1_valid <= 1'b1;
                end else begin
                    r_p0_data  <= mem_out_data;
                    r_p0_addr  <= mem_out_addr;
                    r_p0_valid <= 1'b1;
                end
            end
            if (w_abort) begin
                r_rd  <= 1'b0;
                r_wr  <= 1'b0;
                r_tmo <= 1'b1;
            end
        end
    end

    assign p0_ready    = (r_state == IDLE) && mem_ready;
    assign p1_ready    = (r_state == IDLE) && mem_ready;
    assign p0_out_data = r_p0_data;
    assign p0_out_addr = r_p0_addr;
    assign p0_valid    = r_p0_valid;
    assign p1_out_data = r_p1_data;
    assign p1_out_addr = r_p1_addr;
    assign p1_valid    = r_p1_valid;
    assign mem_read    = r_rd;
    assign mem_write   = r_wr;
    assign mem_address = r_addr;
    assign mem_in_data = r_wdata;
    assign timeout_err = r_tmo;
    assign grant       = r_grant;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized scoreboard bench for mem_arbiter.
// Requesters, memory responder, arbitration model and response monitor.
module tb_mem_arbiter;

    localparam int DW  = 32;
    localparam int AW  = 20;
    localparam int TMO = 4;

    typedef struct {
        int          kind;
        logic [DW-1:0] d;
        logic [AW-1:0] a;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          rd [2];
    logic          wr [2];
    logic [AW-1:0] ad [2];
    logic [DW-1:0] dt [2];
    logic [DW-1:0] p0_od, p1_od;
    logic [AW-1:0] p0_oa, p1_oa;
    logic          p0_v, p1_v, p0_rdy, p1_rdy;
    logic          m_rd, m_wr;
    logic [AW-1:0] m_ad;
    logic [DW-1:0] m_id;
    logic [DW-1:0] mod;
    logic [AW-1:0] mad;
    logic          mv, mrdy;
    logic          tmo, gnt;

    int total = 0;
    int bad   = 0;

    exp_t sb[$];

    bit            s_req [2];
    bit            s_wr  [2];
    logic [AW-1:0] s_ad  [2];
    logic [DW-1:0] s_dt  [2];
    logic          s_ready;

    bit            force_hang = 1'b0;
    int            force_lat  = 0;
    bit            fix_en     = 1'b0;
    logic [DW-1:0] fix_data   = '0;
    int            hang_pct   = 0;
    bit            spur_en    = 1'b0;
    bit            done_flag  = 1'b0;

    mem_arbiter #(
        .DATA_WIDTH  (DW),
        .ADDRESS_BITS(AW),
        .TIMEOUT     (TMO)
    ) dut (
        .clock       (clk),
        .reset       (rst),
        .p0_read     (rd[0]),
        .p0_write    (wr[0]),
        .p0_address  (ad[0]),
        .p0_in_data  (dt[0]),
        .p0_out_data (p0_od),
        .p0_out_addr (p0_oa),
        .p0_valid    (p0_v),
        .p0_ready    (p0_rdy),
        .p1_read     (rd[1]),
        .p1_write    (wr[1]),
        .p1_address  (ad[1]),
        .p1_in_data  (dt[1]),
        .p1_out_data (p1_od),
        .p1_out_addr (p1_oa),
        .p1_valid    (p1_v),
        .p1_ready    (p1_rdy),
        .mem_read    (m_rd),
        .mem_write   (m_wr),
        .mem_address (m_ad),
        .mem_in_data (m_id),
        .mem_out_data(mod),
        .mem_out_addr(mad),
        .mem_valid   (mv),
        .mem_ready   (mrdy),
        .timeout_err (tmo),
        .grant       (gnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Requests as the DUT sees them at the active edge.
    initial begin
        forever begin
            @(posedge clk);
            for (int i = 0; i < 2; i++) begin
                s_req[i] = rd[i] | wr[i];
                s_wr[i]  = wr[i];
                s_ad[i]  = ad[i];
                s_dt[i]  = dt[i];
            end
            s_ready = mrdy;
        end
    end

    // Arbitration model + memory responder; pushes expected responses.
    initial begin
        bit            cmd_on;
        bit            model_last;
        bit            w;
        bit            hang;
        bit            act;
        int            run;
        int            lat;
        int            exp_len;
        bit            sv_wr;
        logic [AW-1:0] sv_ad;
        logic [DW-1:0] sv_id;
        logic [DW-1:0] rdat;
        logic [AW-1:0] raddr;
        exp_t          e;
        mv = 1'b0;
        mod = '0;
        mad = '0;
        cmd_on = 1'b0;
        model_last = 1'b1;
        run = 0;
        lat = 1;
        hang = 1'b0;
        exp_len = 0;
        forever begin
            @(negedge clk);
            mv = 1'b0;
            if (rst) begin
                sb.delete();
                cmd_on = 1'b0;
                model_last = 1'b1;
                run = 0;
            end else begin
                act = m_rd | m_wr;
                if (act && !cmd_on) begin
                    if (s_req[0] && s_req[1]) w = !model_last;
                    else if (s_req[1]) w = 1'b1;
                    else w = 1'b0;
                    chk("req_present", 64'(s_req[0] | s_req[1]), 64'd1);
                    chk("ready_at_issue", 64'(s_ready), 64'd1);
                    chk("grant", 64'(gnt), 64'(w));
                    chk("cmd_wr", 64'(m_wr), 64'(s_wr[w]));
                    chk("cmd_rd", 64'(m_rd), 64'(!s_wr[w]));
                    chk("cmd_addr", 64'(m_ad), 64'(s_ad[w]));
                    if (s_wr[w]) chk("cmd_wdata", 64'(m_id), 64'(s_dt[w]));
                    model_last = w;
                    sv_wr = s_wr[w];
                    sv_ad = s_ad[w];
                    sv_id = s_dt[w];
                    cmd_on = 1'b1;
                    run = 0;
                    lat = (force_lat != 0) ? force_lat : $urandom_range(1, 4);
                    hang = force_hang || ($urandom_range(0, 99) < hang_pct);
                    exp_len = hang ? TMO : lat;
                    rdat = fix_en ? fix_data : $urandom;
                    raddr = AW'($urandom);
                    e.kind = hang ? 2 : int'(w);
                    e.d = rdat;
                    e.a = raddr;
                    sb.push_back(e);
                end else if (act) begin
                    chk("hold_wr", 64'(m_wr), 64'(sv_wr));
                    chk("hold_rd", 64'(m_rd), 64'(!sv_wr));
                    chk("hold_addr", 64'(m_ad), 64'(sv_ad));
                    if (sv_wr) chk("hold_wdata", 64'(m_id), 64'(sv_id));
                end else if (cmd_on) begin
                    chk("cmd_len", 64'(run), 64'(exp_len));
                    cmd_on = 1'b0;
                end
                if (act) begin
                    run++;
                    if (!hang && run == lat) begin
                        mv = 1'b1;
                        mod = rdat;
                        mad = raddr;
                    end
                end else if (spur_en && $urandom_range(0, 7) == 0) begin
                    mv = 1'b1;
                    mod = $urandom;
                    mad = AW'($urandom);
                end
            end
        end
    end

    // Response monitor: pops on every completion or abort pulse.
    initial begin
        logic [DW-1:0] last_out [2];
        exp_t          e;
        last_out[0] = '0;
        last_out[1] = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                last_out[0] = '0;
                last_out[1] = '0;
            end else if (p0_v || p1_v || tmo) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_resp: got v0=%0b v1=%0b tmo=%0b want none",
                             p0_v, p1_v, tmo);
                end else begin
                    e = sb.pop_front();
                    if (e.kind == 2) begin
                        chk("tmo_pulse", 64'(tmo), 64'd1);
                        chk("tmo_no_v0", 64'(p0_v), 64'd0);
                        chk("tmo_no_v1", 64'(p1_v), 64'd0);
                        chk("tmo_cmd_drop", 64'(m_rd | m_wr), 64'd0);
                        chk("tmo_ready", 64'(p0_rdy), 64'(mrdy));
                    end else begin
                        chk("v0", 64'(p0_v), 64'(e.kind == 0));
                        chk("v1", 64'(p1_v), 64'(e.kind == 1));
                        chk("no_tmo", 64'(tmo), 64'd0);
                        if (e.kind == 0) begin
                            chk("p0_data", 64'(p0_od), 64'(e.d));
                            chk("p0_addr", 64'(p0_oa), 64'(e.a));
                            chk("p1_hold", 64'(p1_od), 64'(last_out[1]));
                        end else begin
                            chk("p1_data", 64'(p1_od), 64'(e.d));
                            chk("p1_addr", 64'(p1_oa), 64'(e.a));
                            chk("p0_hold", 64'(p0_od), 64'(last_out[0]));
                        end
                        last_out[e.kind] = e.d;
                    end
                end
            end
        end
    end

    task automatic txn(input int p, input logic r, input logic w,
                       input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input int dly);
        int n;
        repeat (dly) step();
        step();
        rd[p] = r;
        wr[p] = w;
        ad[p] = a;
        dt[p] = d;
        n = 0;
        while (n < 400) begin
            step();
            if ((p == 0) ? p0_v : p1_v) break;
            n++;
        end
        if (n >= 400) begin
            total++;
            bad++;
            $display("FAIL wait_valid: port %0d got no valid want valid", p);
        end
        rd[p] = 1'b0;
        wr[p] = 1'b0;
    endtask

    task automatic port_run(input int p, input int n, input int maxgap);
        int op;
        for (int i = 0; i < n; i++) begin
            op = $urandom_range(0, 2);
            txn(p, op != 1, op != 0, AW'($urandom), $urandom,
                $urandom_range(0, maxgap));
        end
    endtask

    task automatic wait_cmd();
        for (int i = 0; i < 50; i++) begin
            step();
            if (m_rd || m_wr) break;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish want finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        rst = 1'b1;
        mrdy = 1'b1;
        for (int i = 0; i < 2; i++) begin
            rd[i] = 1'b0;
            wr[i] = 1'b0;
            ad[i] = '0;
            dt[i] = '0;
        end
        repeat (3) step();
        rst = 1'b0;
        step();
        chk("rst_mem_rd", 64'(m_rd), 64'd0);
        chk("rst_mem_wr", 64'(m_wr), 64'd0);
        chk("rst_mem_addr", 64'(m_ad), 64'd0);
        chk("rst_mem_wdata", 64'(m_id), 64'd0);
        chk("rst_p0_valid", 64'(p0_v), 64'd0);
        chk("rst_p1_valid", 64'(p1_v), 64'd0);
        chk("rst_p0_data", 64'(p0_od), 64'd0);
        chk("rst_p1_data", 64'(p1_od), 64'd0);
        chk("rst_p0_addr", 64'(p0_oa), 64'd0);
        chk("rst_p1_addr", 64'(p1_oa), 64'd0);
        chk("rst_tmo", 64'(tmo), 64'd0);
        chk("rst_grant", 64'(gnt), 64'd1);
        chk("rst_p0_ready", 64'(p0_rdy), 64'd1);
        chk("rst_p1_ready", 64'(p1_rdy), 64'd1);

        force_lat = 2;
        fix_en = 1'b1;
        fix_data = 32'hDEADBEEF;
        txn(0, 1'b1, 1'b0, 20'h00010, '0, 0);
        fix_en = 1'b0;

        force_lat = 3;
        fork
            txn(1, 1'b0, 1'b1, 20'h00400, 32'h12345678, 0);
            txn(0, 1'b1, 1'b0, 20'h00ABC, '0, 2);
        join
        force_lat = 0;

        force_hang = 1'b1;
        fork
            txn(0, 1'b1, 1'b0, 20'h00123, '0, 0);
            begin
                wait_cmd();
                force_hang = 1'b0;
            end
        join

        mrdy = 1'b0;
        fork
            txn(1, 1'b0, 1'b1, 20'h00777, 32'hCAFEF00D, 0);
            begin
                for (int i = 0; i < 5; i++) begin
                    step();
                    chk("rdy_low_no_cmd", 64'(m_rd | m_wr), 64'd0);
                    chk("rdy_low_p1_ready", 64'(p1_rdy), 64'd0);
                end
                mrdy = 1'b1;
                step();
                chk("cmd_after_ready", 64'(m_wr), 64'd1);
            end
        join

        force_hang = 1'b1;
        step();
        rd[0] = 1'b1;
        ad[0] = 20'h0BEEF;
        wait_cmd();
        force_hang = 1'b0;
        step();
        rst = 1'b1;
        step();
        chk("busy_rst_mem_rd", 64'(m_rd), 64'd0);
        chk("busy_rst_mem_wr", 64'(m_wr), 64'd0);
        chk("busy_rst_p0_valid", 64'(p0_v), 64'd0);
        chk("busy_rst_tmo", 64'(tmo), 64'd0);
        chk("busy_rst_grant", 64'(gnt), 64'd1);
        rd[0] = 1'b0;
        rst = 1'b0;
        step();
        fork
            txn(0, 1'b1, 1'b0, 20'h00011, '0, 0);
            txn(1, 1'b1, 1'b0, 20'h00022, '0, 0);
        join

        hang_pct = 8;
        spur_en = 1'b1;
        fork
            begin
                fork
                    port_run(0, 40, 3);
                    port_run(1, 40, 3);
                join
                done_flag = 1'b1;
            end
            begin
                while (!done_flag) begin
                    step();
                    mrdy = ($urandom_range(0, 3) != 0);
                end
                mrdy = 1'b1;
            end
        join

        hang_pct = 0;
        fork
            port_run(0, 20, 0);
            port_run(1, 20, 0);
        join

        repeat (5) step();
        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester arbiter that shares one mem_interface-style port between instruction fetch (port 0) and the data memory unit (port 1).
- Sits between the core's fetch/memory stages and the shared memory interface.
- Latches one request at a time, drives it downstream until the memory completes, and routes the response back to the granted requester.
- Round-robin fairness; a watchdog aborts hung transactions.

Parameters:
DATA_WIDTH, 32, data bus width
ADDRESS_BITS, 20, address width
TIMEOUT, 255, max cycles in BUSY before abort; 0 disables watchdog (max 65535)

Ports:
clock  input  1  system clock; all logic on posedge
reset  input  1  synchronous, active-high reset
p0_read  input  1  port 0 read request (level, held until p0_valid)
p0_write  input  1  port 0 write request (level, held until p0_valid)
p0_address  input  ADDRESS_BITS  port 0 address
p0_in_data  input  DATA_WIDTH  port 0 write data
p0_out_data  output  DATA_WIDTH  port 0 read data
p0_out_addr  output  ADDRESS_BITS  address of completed port 0 access
p0_valid  output  1  1-cycle completion pulse to port 0
p0_ready  output  1  arbiter idle and able to accept port 0
p1_read, p1_write, p1_address, p1_in_data, p1_out_data, p1_out_addr, p1_valid, p1_ready  same as port 0, for port 1
mem_read  output  1  downstream read command
mem_write  output  1  downstream write command
mem_address  output  ADDRESS_BITS  downstream address
mem_in_data  output  DATA_WIDTH  downstream write data
mem_out_data  input  DATA_WIDTH  downstream read data
mem_out_addr  input  ADDRESS_BITS  downstream returned address
mem_valid  input  1  downstream completion pulse (reads and writes)
mem_ready  input  1  downstream can accept a command
timeout_err  output  1  1-cycle pulse when watchdog aborts
grant  output  1  port currently or last granted (0/1)

Behaviour:
- States: IDLE, BUSY, RESP.
- Reset values: state=IDLE; all mem_* outputs=0; pN_valid=0; pN_out_data=0; pN_out_addr=0; timeout_err=0; grant=1, so port 0 wins the first tie; watchdog counter=0.
- pN_ready = (state==IDLE) && mem_ready, combinational.
- IDLE:
  - If mem_ready and any request (read|write) is present, select a port, latch grant, op, address and data, and go to BUSY.
  - With one requester, that port wins.
  - With both requesting, the port != grant (the last grant) wins.
  - If read and write are both asserted on a port, write wins.
  - With mem_ready low, stay in IDLE; requests are ignored.
- BUSY:
  - mem_read/mem_write/mem_address/mem_in_data are driven from the latched registers, held stable every cycle until completion.
  - The first mem_* cycle is the cycle after the request was sampled.
  - On mem_valid: capture mem_out_data and mem_out_addr into the granted port's out registers, drop the mem command, go to RESP.
  - Watchdog counts BUSY cycles. If TIMEOUT != 0 and the count reaches TIMEOUT without mem_valid: drop the command, pulse timeout_err, return to IDLE with no pN_valid.
- RESP:
  - Assert granted pN_valid for exactly one cycle with its out_data/out_addr, then go to IDLE.
  - Requester must deassert its request by the end of the RESP cycle.
  - The ungranted port's outputs are unchanged.
- Latency: request sampled at edge t; mem command visible in t+1. If mem_valid is seen in cycle t+k, pN_valid is in t+k+1. Minimum turnaround is 3 cycles per transaction.
- A mem_valid outside BUSY is ignored.
- Reset mid-BUSY or mid-RESP: abort immediately to reset values with no valid pulse; grant returns to 1.
- pN_out_data holds its last value until the next completion on that port.
- Request changes during BUSY have no effect; the latched values are used.

Test Plan:
- Single read: p0_read, addr 0x00010, memory returns 0xDEADBEEF after 2 cycles -> mem_read high 2 cycles with mem_address=0x00010; p0_valid 1 cycle with p0_out_data=0xDEADBEEF; p1_valid stays 0.
- Simultaneous requests over 4 back-to-back transactions: both ports request continuously -> grants alternate 0,1,0,1; every transaction ≥3 cycles apart.
- Port 1 write 0x12345678 to 0x00400 while port 0 requests mid-transaction -> mem_write/mem_in_data stable until mem_valid; then port 0 is granted next.
- Watchdog: TIMEOUT=4, memory never asserts mem_valid -> after 4 BUSY cycles timeout_err pulses once, mem_read drops, no p0_valid, state IDLE, p0_ready high.
- Reset asserted during BUSY -> next cycle all mem_* 0, no valid pulse; after release a tie is granted to port 0.
- mem_ready low: requests held 5 cycles -> no mem command issued; command issues the cycle after mem_ready rises.
